// File: rtl/ucie_debug_trace_engine.sv
// Trace capture engine: trigger-qualified sample buffering with timestamps and
// a valid/ready readout port that drains oldest-first once a run is done.
module ucie_debug_trace_engine #(
  parameter int unsigned TRACE_WIDTH = 64,
  parameter int unsigned TRACE_DEPTH = 256,
  parameter int unsigned NUM_TRIG    = 32,
  parameter int unsigned TS_WIDTH    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [TRACE_WIDTH-1:0]       trace_data,
  input  logic                         trace_valid,
  input  logic [NUM_TRIG-1:0]          trig_src,
  input  logic [NUM_TRIG-1:0]          debug_trigger_mask,
  input  logic                         trig_match_all,
  input  logic                         debug_capture_enable,
  input  logic [1:0]                   capture_mode,
  input  logic [$clog2(TRACE_DEPTH):0] post_trig_count,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [TRACE_WIDTH-1:0]       rd_data,
  output logic [TS_WIDTH-1:0]          rd_timestamp,
  output logic [TS_WIDTH-1:0]          debug_timestamp,
  output logic [1:0]                   engine_state,
  output logic [$clog2(TRACE_DEPTH):0] debug_trace_count,
  output logic                         trigger_hit,
  output logic                         trace_wrapped,
  output logic [15:0]                  dropped_count
);

  localparam int unsigned AW = $clog2(TRACE_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_START  = 2'd0,
    MODE_CENTER = 2'd1,
    MODE_FREE   = 2'd2
  } mode_e;

  state_e            state;
  state_e            state_nxt;
  mode_e             mode_q;
  logic [CW-1:0]     post_q;
  logic [CW-1:0]     post_cnt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [TS_WIDTH-1:0] ts;

  logic [TRACE_WIDTH-1:0] mem_data [TRACE_DEPTH];
  logic [TS_WIDTH-1:0]    mem_ts   [TRACE_DEPTH];

  logic trig_fire;
  logic full;
  logic do_clear;
  logic do_store;
  logic do_pop;
  logic set_trig;
  logic set_wrap;
  logic inc_drop;
  logic load_post;
  logic dec_post;

  // Trigger qualification; an empty mask never fires, even in AND mode.
  always_comb begin
    trig_fire = 1'b0;
    if (debug_trigger_mask != '0) begin
      if (trig_match_all) trig_fire = &(trig_src | ~debug_trigger_mask);
      else                trig_fire = |(trig_src & debug_trigger_mask);
    end
  end

  assign full   = (count == CW'(TRACE_DEPTH));
  assign rd_ptr = wr_ptr - count[AW-1:0];

  // Next-state and per-cycle action strobes.
  always_comb begin
    state_nxt = state;
    do_clear  = 1'b0;
    do_store  = 1'b0;
    do_pop    = 1'b0;
    set_trig  = 1'b0;
    set_wrap  = 1'b0;
    inc_drop  = 1'b0;
    load_post = 1'b0;
    dec_post  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (debug_capture_enable) begin
          state_nxt = ST_ARMED;
          do_clear  = 1'b1;
        end
      end
      ST_ARMED: begin
        if (!debug_capture_enable) begin
          state_nxt = ST_DONE;
          inc_drop  = trace_valid && (mode_q == MODE_START);
        end else begin
          set_trig = trig_fire;
          case (mode_q)
            MODE_CENTER: begin
              do_store = trace_valid;
              set_wrap = trace_valid && full;
              if (trig_fire) begin
                load_post = 1'b1;
                state_nxt = (post_q == '0) ? ST_DONE : ST_CAPTURE;
              end
            end
            MODE_FREE: begin
              do_store = trace_valid;
              set_wrap = trace_valid && full;
            end
            default: begin
              if (trig_fire) begin
                state_nxt = ST_CAPTURE;
                do_store  = trace_valid;
              end else begin
                inc_drop = trace_valid;
              end
            end
          endcase
        end
      end
      ST_CAPTURE: begin
        if (!debug_capture_enable) begin
          state_nxt = ST_DONE;
        end else begin
          set_trig = trig_fire;
          if (mode_q == MODE_CENTER) begin
            do_store = trace_valid;
            set_wrap = trace_valid && full;
            if (trace_valid) begin
              dec_post = 1'b1;
              if (post_cnt <= CW'(1)) state_nxt = ST_DONE;
            end
          end else begin
            // Start-triggered capture fills the buffer once and never overwrites.
            do_store = trace_valid && !full;
            if (trace_valid && (count == CW'(TRACE_DEPTH - 1))) state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        inc_drop = trace_valid;
        if (count == '0) begin
          state_nxt = ST_IDLE;
        end else if (rd_ready) begin
          do_pop = 1'b1;
          if (count == CW'(1)) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, pointers, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      mode_q        <= MODE_START;
      post_q        <= '0;
      post_cnt      <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      ts            <= '0;
      trigger_hit   <= 1'b0;
      trace_wrapped <= 1'b0;
      dropped_count <= '0;
    end else begin
      state <= state_nxt;
      ts    <= ts + TS_WIDTH'(1);
      if (do_clear) begin
        wr_ptr        <= '0;
        count         <= '0;
        trigger_hit   <= 1'b0;
        trace_wrapped <= 1'b0;
        dropped_count <= '0;
        post_q        <= post_trig_count;
        mode_q        <= (capture_mode == 2'd3) ? MODE_START : mode_e'(capture_mode);
      end
      if (do_store) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (!full) count <= count + CW'(1);
      end
      if (do_pop) count <= count - CW'(1);
      if (set_trig) trigger_hit <= 1'b1;
      if (set_wrap) trace_wrapped <= 1'b1;
      if (inc_drop && (dropped_count != 16'hFFFF)) dropped_count <= dropped_count + 16'd1;
      if (load_post)     post_cnt <= post_q;
      else if (dec_post) post_cnt <= post_cnt - CW'(1);
    end
  end

  // Trace storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_store) begin
      mem_data[wr_ptr] <= trace_data;
      mem_ts[wr_ptr]   <= ts;
    end
  end

  assign rd_valid          = (state == ST_DONE) && (count != '0);
  assign rd_data           = mem_data[rd_ptr];
  assign rd_timestamp      = mem_ts[rd_ptr];
  assign debug_timestamp   = ts;
  assign engine_state      = state;
  assign debug_trace_count = count;

endmodule

// File: tb/tb_ucie_debug_trace_engine.sv
// Directed bench for the trace engine at depth 8 with four trigger sources.
module tb_ucie_debug_trace_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] trace_data = '0;
  logic        trace_valid = 1'b0;
  logic [3:0]  trig_src = '0;
  logic [3:0]  debug_trigger_mask = '0;
  logic        trig_match_all = 1'b0;
  logic        debug_capture_enable = 1'b0;
  logic [1:0]  capture_mode = '0;
  logic [3:0]  post_trig_count = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [15:0] rd_timestamp;
  logic [15:0] debug_timestamp;
  logic [1:0]  engine_state;
  logic [3:0]  debug_trace_count;
  logic        trigger_hit;
  logic        trace_wrapped;
  logic [15:0] dropped_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ucie_debug_trace_engine #(
    .TRACE_WIDTH(16), .TRACE_DEPTH(8), .NUM_TRIG(4), .TS_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .trace_data(trace_data), .trace_valid(trace_valid),
    .trig_src(trig_src), .debug_trigger_mask(debug_trigger_mask),
    .trig_match_all(trig_match_all), .debug_capture_enable(debug_capture_enable),
    .capture_mode(capture_mode), .post_trig_count(post_trig_count),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_timestamp(rd_timestamp), .debug_timestamp(debug_timestamp),
    .engine_state(engine_state), .debug_trace_count(debug_trace_count),
    .trigger_hit(trigger_hit), .trace_wrapped(trace_wrapped),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One cycle; cyc tracks the expected timestamp of the current cycle.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    trace_data = 16'(32'h5000 + cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    debug_capture_enable = 1'b0; trace_valid = 1'b0; trig_src = '0;
    rd_ready = 1'b0; debug_trigger_mask = '0; trig_match_all = 1'b0;
    capture_mode = '0; post_trig_count = '0;
    tick(); tick();
    cyc = 0;
    trace_data = 16'h5000;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (engine_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", engine_state); end
    n_checks++; if (debug_trace_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", debug_trace_count); end
    n_checks++; if (debug_timestamp !== 16'd0) begin n_fail++; $display("FAIL reset_ts: got %0d want 0", debug_timestamp); end
    n_checks++; if ({rd_valid, trigger_hit, trace_wrapped} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {rd_valid, trigger_hit, trace_wrapped}); end
    n_checks++; if (dropped_count !== 16'd0) begin n_fail++; $display("FAIL reset_dropped: got %0d want 0", dropped_count); end
    tick();
    n_checks++; if (debug_timestamp !== 16'd1) begin n_fail++; $display("FAIL ts_increment: got %0d want 1", debug_timestamp); end
  endtask

  task automatic test_start();
    do_reset();
    debug_trigger_mask = 4'b0010; trig_match_all = 1'b0; capture_mode = 2'd0;
    debug_capture_enable = 1'b1; trace_valid = 1'b1;
    tick();
    n_checks++; if (engine_state !== 2'd1) begin n_fail++; $display("FAIL start_armed: got %0d want 1", engine_state); end
    while (cyc < 10) tick();
    trig_src = 4'b0010;
    tick();
    trig_src = '0;
    n_checks++; if (engine_state !== 2'd2) begin n_fail++; $display("FAIL start_capture: got %0d want 2", engine_state); end
    n_checks++; if (trigger_hit !== 1'b1) begin n_fail++; $display("FAIL start_trig_hit: got %0d want 1", trigger_hit); end
    n_checks++; if (debug_trace_count !== 4'd1) begin n_fail++; $display("FAIL start_first_store: got %0d want 1", debug_trace_count); end
    while (cyc < 17) tick();
    n_checks++; if ({engine_state, debug_trace_count} !== {2'd2, 4'd7}) begin n_fail++; $display("FAIL start_t17: got state %0d count %0d want 2/7", engine_state, debug_trace_count); end
    tick();
    n_checks++; if (engine_state !== 2'd3) begin n_fail++; $display("FAIL start_done_t18: got %0d want 3", engine_state); end
    n_checks++; if (debug_trace_count !== 4'd8) begin n_fail++; $display("FAIL start_full: got %0d want 8", debug_trace_count); end
    n_checks++; if (trace_wrapped !== 1'b0) begin n_fail++; $display("FAIL start_no_wrap: got %0d want 0", trace_wrapped); end
    n_checks++; if (dropped_count !== 16'd9) begin n_fail++; $display("FAIL start_dropped: got %0d want 9", dropped_count); end
    trace_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL start_rd_valid[%0d]: got %0d want 1", i, rd_valid); end
      n_checks++; if (rd_timestamp !== 16'(10 + i)) begin n_fail++; $display("FAIL start_rd_ts[%0d]: got %0d want %0d", i, rd_timestamp, 10 + i); end
      n_checks++; if (rd_data !== 16'(32'h5000 + 10 + i)) begin n_fail++; $display("FAIL start_rd_data[%0d]: got %h want %h", i, rd_data, 16'(32'h5000 + 10 + i)); end
      tick();
    end
    n_checks++; if ({engine_state, rd_valid} !== {2'd0, 1'b0}) begin n_fail++; $display("FAIL start_idle: got state %0d rd_valid %0d want 0/0", engine_state, rd_valid); end
    debug_capture_enable = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_center();
    do_reset();
    debug_trigger_mask = 4'b0001; capture_mode = 2'd1; post_trig_count = 4'd3;
    debug_capture_enable = 1'b1; trace_valid = 1'b1;
    while (cyc < 20) tick();
    trig_src = 4'b0001;
    tick();
    trig_src = '0;
    n_checks++; if (engine_state !== 2'd2) begin n_fail++; $display("FAIL center_capture: got %0d want 2", engine_state); end
    while (cyc < 23) tick();
    n_checks++; if (engine_state !== 2'd2) begin n_fail++; $display("FAIL center_t23: got %0d want 2", engine_state); end
    tick();
    n_checks++; if (engine_state !== 2'd3) begin n_fail++; $display("FAIL center_done: got %0d want 3", engine_state); end
    n_checks++; if (debug_trace_count !== 4'd8) begin n_fail++; $display("FAIL center_count: got %0d want 8", debug_trace_count); end
    n_checks++; if ({trace_wrapped, trigger_hit} !== 2'b11) begin n_fail++; $display("FAIL center_flags: got %b want 11", {trace_wrapped, trigger_hit}); end
    n_checks++; if (dropped_count !== 16'd0) begin n_fail++; $display("FAIL center_dropped: got %0d want 0", dropped_count); end
    trace_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rd_timestamp !== 16'(16 + i)) begin n_fail++; $display("FAIL center_rd_ts[%0d]: got %0d want %0d", i, rd_timestamp, 16 + i); end
      n_checks++; if (rd_data !== 16'(32'h5000 + 16 + i)) begin n_fail++; $display("FAIL center_rd_data[%0d]: got %h want %h", i, rd_data, 16'(32'h5000 + 16 + i)); end
      tick();
    end
    n_checks++; if (engine_state !== 2'd0) begin n_fail++; $display("FAIL center_idle: got %0d want 0", engine_state); end
  endtask

  task automatic test_center_zero_post();
    do_reset();
    debug_trigger_mask = 4'b0001; capture_mode = 2'd1; post_trig_count = 4'd0;
    debug_capture_enable = 1'b1; trace_valid = 1'b1;
    while (cyc < 4) tick();
    trig_src = 4'b0001;
    tick();
    trig_src = '0; trace_valid = 1'b0;
    n_checks++; if ({engine_state, debug_trace_count} !== {2'd3, 4'd4}) begin n_fail++; $display("FAIL center0_done: got state %0d count %0d want 3/4", engine_state, debug_trace_count); end
    n_checks++; if (rd_timestamp !== 16'd1) begin n_fail++; $display("FAIL center0_oldest: got %0d want 1", rd_timestamp); end
  endtask

  task automatic test_and_mode();
    do_reset();
    capture_mode = 2'd0; debug_trigger_mask = 4'b0101; trig_match_all = 1'b1;
    trig_src = 4'b0001; debug_capture_enable = 1'b1;
    while (cyc < 5) tick();
    n_checks++; if ({engine_state, trigger_hit} !== {2'd1, 1'b0}) begin n_fail++; $display("FAIL and_partial: got state %0d hit %0d want 1/0", engine_state, trigger_hit); end
    trig_src = 4'b0101;
    tick();
    n_checks++; if ({engine_state, trigger_hit} !== {2'd2, 1'b1}) begin n_fail++; $display("FAIL and_full: got state %0d hit %0d want 2/1", engine_state, trigger_hit); end
    n_checks++; if (debug_trace_count !== 4'd0) begin n_fail++; $display("FAIL and_no_store: got %0d want 0", debug_trace_count); end
    do_reset();
    debug_trigger_mask = 4'b0000; trig_match_all = 1'b1; trig_src = 4'b1111;
    debug_capture_enable = 1'b1;
    while (cyc < 4) tick();
    n_checks++; if ({engine_state, trigger_hit} !== {2'd1, 1'b0}) begin n_fail++; $display("FAIL mask0_and: got state %0d hit %0d want 1/0", engine_state, trigger_hit); end
    trig_match_all = 1'b0;
    tick(); tick();
    n_checks++; if ({engine_state, trigger_hit} !== {2'd1, 1'b0}) begin n_fail++; $display("FAIL mask0_or: got state %0d hit %0d want 1/0", engine_state, trigger_hit); end
  endtask

  task automatic test_free_readout();
    logic [3:0] pat;
    int pops;
    int exp_ts;
    pat = 4'b1101;
    pops = 0;
    exp_ts = 1;
    do_reset();
    capture_mode = 2'd2; debug_capture_enable = 1'b1; trace_valid = 1'b1;
    while (cyc < 4) tick();
    trace_valid = 1'b0; debug_capture_enable = 1'b0;
    tick();
    n_checks++; if ({engine_state, debug_trace_count} !== {2'd3, 4'd3}) begin n_fail++; $display("FAIL free_done: got state %0d count %0d want 3/3", engine_state, debug_trace_count); end
    trace_valid = 1'b1;
    tick(); tick();
    trace_valid = 1'b0;
    n_checks++; if (dropped_count !== 16'd2) begin n_fail++; $display("FAIL free_dropped: got %0d want 2", dropped_count); end
    for (int i = 0; i < 4; i++) begin
      rd_ready = pat[i];
      if (rd_valid && rd_ready) begin
        n_checks++; if (rd_timestamp !== 16'(exp_ts)) begin n_fail++; $display("FAIL free_rd_ts[%0d]: got %0d want %0d", i, rd_timestamp, exp_ts); end
        pops++;
        exp_ts++;
      end
      tick();
    end
    rd_ready = 1'b0;
    n_checks++; if (pops !== 3) begin n_fail++; $display("FAIL free_pops: got %0d want 3", pops); end
    n_checks++; if ({engine_state, debug_trace_count, rd_valid} !== {2'd0, 4'd0, 1'b0}) begin n_fail++; $display("FAIL free_idle: got state %0d count %0d rd_valid %0d want 0/0/0", engine_state, debug_trace_count, rd_valid); end
  endtask

  task automatic test_reset_mid_capture();
    do_reset();
    capture_mode = 2'd0; debug_trigger_mask = 4'b0001;
    debug_capture_enable = 1'b1; trace_valid = 1'b1;
    while (cyc < 3) tick();
    trig_src = 4'b0001;
    tick();
    trig_src = '0;
    while (cyc < 8) tick();
    n_checks++; if ({engine_state, debug_trace_count} !== {2'd2, 4'd5}) begin n_fail++; $display("FAIL mid_pre: got state %0d count %0d want 2/5", engine_state, debug_trace_count); end
    n_checks++; if (dropped_count !== 16'd2) begin n_fail++; $display("FAIL mid_dropped: got %0d want 2", dropped_count); end
    reset = 1'b1;
    tick();
    n_checks++; if ({engine_state, debug_trace_count, rd_valid} !== {2'd0, 4'd0, 1'b0}) begin n_fail++; $display("FAIL mid_reset: got state %0d count %0d rd_valid %0d want 0/0/0", engine_state, debug_trace_count, rd_valid); end
    n_checks++; if (debug_timestamp !== 16'd0) begin n_fail++; $display("FAIL mid_reset_ts: got %0d want 0", debug_timestamp); end
    n_checks++; if ({trigger_hit, dropped_count} !== 17'd0) begin n_fail++; $display("FAIL mid_reset_flags: got hit %0d dropped %0d want 0/0", trigger_hit, dropped_count); end
    reset = 1'b0;
    debug_capture_enable = 1'b0; trace_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_center();
    test_center_zero_post();
    test_and_mode();
    test_free_readout();
    test_reset_mid_capture();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
